// File: rtl/clkfreq_meter.sv
// Multi-channel clock frequency meter: resynchronises Gray-coded prescaled counters and accumulates
// their advance over a gate window of clk cycles. Defining CLKFREQ_METER_ALARM_EN adds the sticky low-frequency alarm.
module clkfreq_meter #(
    parameter int NCH       = 4,
    parameter int CW        = 8,
    parameter int FW        = 32,
`ifdef CLKFREQ_METER_ALARM_EN
    parameter int ALARM_MIN = 16,
`endif
    parameter int GW        = 24
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [NCH*CW-1:0]   cnt_gray,
    input  logic                enable,
    input  logic [GW-1:0]       gate,
`ifdef CLKFREQ_METER_ALARM_EN
    input  logic                alarm_clr,
    output logic [NCH-1:0]      alarm,
`endif
    output logic [NCH*FW-1:0]   freq_cnt,
    output logic                valid,
    output logic                busy,
    output logic [NCH-1:0]      ovf
);

    typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

    state_t                 state;
    logic [NCH-1:0][CW-1:0] sync1, sync2, bin, prev, delta;
    logic [NCH-1:0][FW-1:0] acc, acc_next;
    logic [NCH-1:0]         acc_sat, carry;
    logic [GW-1:0]          gcnt;
    logic                   start_ok, last;
`ifdef CLKFREQ_METER_ALARM_EN
    logic [NCH-1:0]         low;
`endif

    assign start_ok = enable && (gate != '0);
    assign last     = (gcnt == GW'(1));

    // NOTE: every combinational output gets a default first, so no path can leave it unassigned (no latch).
    always_comb begin
        bin      = '0;
        delta    = '0;
        acc_next = '0;
        carry    = '0;
        for (int i = 0; i < NCH; i++) begin
            // Binary bit b of a Gray word is the parity of Gray bits b and above.
            for (int b = 0; b < CW; b++) begin
                bin[i][b] = ^(sync2[i] >> b);
            end
            delta[i] = bin[i] - prev[i];
            {carry[i], acc_next[i]} = {1'b0, acc[i]} + {{(FW + 1 - CW){1'b0}}, delta[i]};
            if (carry[i]) begin
                acc_next[i] = '1;
            end
        end
    end

`ifdef CLKFREQ_METER_ALARM_EN
    always_comb begin
        low = '0;
        for (int i = 0; i < NCH; i++) begin
            low[i] = (acc_next[i] < FW'(ALARM_MIN));
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments only; the combinational block above uses blocking.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            // NOTE: the synchroniser and prev flops are reset like any other state so the first deltas are defined.
            state    <= IDLE;
            sync1    <= '0;
            sync2    <= '0;
            prev     <= '0;
            acc      <= '0;
            acc_sat  <= '0;
            gcnt     <= '0;
            freq_cnt <= '0;
            ovf      <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
`ifdef CLKFREQ_METER_ALARM_EN
            alarm    <= '0;
`endif
        end else begin
            sync1 <= cnt_gray;
            sync2 <= sync1;
            prev  <= bin;
            valid <= 1'b0;
`ifdef CLKFREQ_METER_ALARM_EN
            if (alarm_clr) begin
                alarm <= '0;
            end
`endif
            unique case (state)
                IDLE: begin
                    acc     <= '0;
                    acc_sat <= '0;
                    if (start_ok) begin
                        state <= ARM;
                        busy  <= 1'b1;
                    end
                end
                ARM: begin
                    acc     <= '0;
                    acc_sat <= '0;
                    gcnt    <= gate;
                    state   <= RUN;
                end
                RUN: begin
                    if (last) begin
                        freq_cnt <= acc_next;
                        ovf      <= acc_sat | carry;
                        valid    <= 1'b1;
`ifdef CLKFREQ_METER_ALARM_EN
                        alarm    <= (alarm_clr ? '0 : alarm) | low;
`endif
                        // Next window starts on the following cycle without an ARM step.
                        acc      <= '0;
                        acc_sat  <= '0;
                        gcnt     <= gate;
                        if (!start_ok) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (!enable) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        acc     <= '0;
                        acc_sat <= '0;
                    end else begin
                        acc     <= acc_next;
                        acc_sat <= acc_sat | carry;
                        gcnt    <= gcnt - GW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
